// File: rtl/aes_key_expand_pkg.sv
// Shared types and constants for the iterative AES-128 key-schedule engine.
// Optional inverse-order support is enabled by AES_KEY_EXPAND_INV_EN.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Out-of-range round indices yield zero so the unused path never reads past the table.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
    return v;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-load / round-key handshake bundle between the key source, the engine and the round datapath.
// Carries the inv request only when AES_KEY_EXPAND_INV_EN is defined.
interface aes_key_expand_if;
  import aes_pkg::*;

  logic       start;
  aes_block_t key_in;
`ifdef AES_KEY_EXPAND_INV_EN
  logic       inv;
`endif
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_round;
  aes_block_t out_key;

  modport master (
`ifdef AES_KEY_EXPAND_INV_EN
    output inv,
`endif
    output start, key_in, out_ready,
    input  busy, out_valid, out_round, out_key
  );

  modport slave (
`ifdef AES_KEY_EXPAND_INV_EN
    input  inv,
`endif
    input  start, key_in, out_ready,
    output busy, out_valid, out_round, out_key
  );

endinterface

// File: rtl/aes_key_expand_sub_word.sv
// SubWord: four parallel AES S-box lookups over a 32-bit word, plus the S-box itself.
// Purely combinational; the table is a constant so it maps to LUTs or ROM.
module sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so byte n starts at bit 8*(255-n) = {~n, 3'b000}.
  assign o_data = SBOX_TABLE[{~i_data, 3'b000} +: 8];

endmodule

module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t i_word,
  output aes_word_t o_word
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      sbox u_sbox (
        .i_data(i_word[8*gi +: 8]),
        .o_data(o_word[8*gi +: 8])
      );
    end
  endgenerate

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10, one per out_valid/out_ready handshake.
// Defining AES_KEY_EXPAND_INV_EN adds an inv request that walks the schedule backwards from round 10.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  aes_key_expand_if.slave  bus
);

  state_t     r_state, w_state_next;
  aes_block_t r_key, w_key_next;
  logic [3:0] r_round, w_round_next;
`ifdef AES_KEY_EXPAND_INV_EN
  logic       r_inv, w_inv_next;
`endif

  aes_word_t  w_w0, w_w1, w_w2, w_w3;
  aes_word_t  w_sub_src, w_sub_in, w_sub_out, w_t;
  aes_block_t w_step_key;
  logic [7:0] w_rcon;
  logic [3:0] w_last_round;
  logic [3:0] w_start_round;
  logic [3:0] w_round_step;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

`ifdef AES_KEY_EXPAND_INV_EN
  // Backwards, the word fed to SubWord is the previous round's w3, recovered as w3^w2.
  assign w_sub_src     = r_inv ? (w_w3 ^ w_w2) : w_w3;
  assign w_rcon        = r_inv ? rcon_of(r_round) : rcon_of(r_round + 4'd1);
  assign w_last_round  = r_inv ? 4'd0 : LAST_ROUND;
  assign w_start_round = bus.inv ? LAST_ROUND : 4'd0;
  assign w_round_step  = r_inv ? (r_round - 4'd1) : (r_round + 4'd1);
`else
  assign w_sub_src     = w_w3;
  assign w_rcon        = rcon_of(r_round + 4'd1);
  assign w_last_round  = LAST_ROUND;
  assign w_start_round = 4'd0;
  assign w_round_step  = r_round + 4'd1;
`endif

  assign w_sub_in = {w_sub_src[23:0], w_sub_src[31:24]};

  aes_sub_word u_sub_word (
    .i_word(w_sub_in),
    .o_word(w_sub_out)
  );

  assign w_t = w_sub_out ^ {w_rcon, 24'h0};

`ifdef AES_KEY_EXPAND_INV_EN
  always_comb begin
    w_step_key = {w_w0 ^ w_t,
                  w_w1 ^ w_w0 ^ w_t,
                  w_w2 ^ w_w1 ^ w_w0 ^ w_t,
                  w_w3 ^ w_w2 ^ w_w1 ^ w_w0 ^ w_t};
    if (r_inv) begin
      w_step_key = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};
    end
  end
`else
  assign w_step_key = {w_w0 ^ w_t,
                       w_w1 ^ w_w0 ^ w_t,
                       w_w2 ^ w_w1 ^ w_w0 ^ w_t,
                       w_w3 ^ w_w2 ^ w_w1 ^ w_w0 ^ w_t};
`endif

  always_comb begin
    w_state_next = r_state;
    w_key_next   = r_key;
    w_round_next = r_round;
`ifdef AES_KEY_EXPAND_INV_EN
    w_inv_next   = r_inv;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = EMIT;
          w_key_next   = bus.key_in;
          w_round_next = w_start_round;
`ifdef AES_KEY_EXPAND_INV_EN
          w_inv_next   = bus.inv;
`endif
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (r_round == w_last_round) begin
            w_state_next = IDLE;
          end else begin
            w_key_next   = w_step_key;
            w_round_next = w_round_step;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_round <= '0;
`ifdef AES_KEY_EXPAND_INV_EN
      r_inv   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_key   <= w_key_next;
      r_round <= w_round_next;
`ifdef AES_KEY_EXPAND_INV_EN
      r_inv   <= w_inv_next;
`endif
    end
  end

  assign bus.busy      = (r_state == EMIT);
  assign bus.out_valid = (r_state == EMIT);
  assign bus.out_round = r_round;
  assign bus.out_key   = r_key;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus queues expected round keys, a negedge monitor checks handshakes.
// Exercises the inverse order too when AES_KEY_EXPAND_INV_EN is defined.
module tb_aes_key_expand;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_expand_if bus ();

  aes_key_expand dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
    bit           chk_key;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_ready = 1'b0;

  logic [127:0] fips_keys [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [127:0] zero_keys [0:10] = '{
    128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_fwd(input bit zero_key);
    for (int i = 0; i <= 10; i++) begin
      exp_t e;
      e.round   = 4'(i);
      e.key     = zero_key ? zero_keys[i] : fips_keys[i];
      e.chk_key = !zero_key || (i <= 2) || (i == 10);
      sb_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] key, input bit inv_req);
    tick();
    bus.key_in = key;
    bus.start  = 1'b1;
`ifdef AES_KEY_EXPAND_INV_EN
    bus.inv    = inv_req;
`else
    if (inv_req) $display("inverse request ignored in forward-only build");
`endif
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while ((sb_q.size() != 0 || bus.busy) && cyc < 400) begin
      tick();
      cyc++;
    end
    if (cyc >= 400) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb_q.size());
    end
    check("idle_after_done", 128'(bus.busy), 128'(1'b0));
  endtask

  task automatic wait_round(input logic [3:0] r);
    int cyc = 0;
    while (bus.out_round != r && cyc < 100) begin
      tick();
      cyc++;
    end
    check("reach_round", 128'(bus.out_round), 128'(r));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  128'(bus.busy),      128'(1'b0));
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(1'b0));
    check({tag, "_round"}, 128'(bus.out_round), 128'(4'd0));
    check({tag, "_key"},   bus.out_key,         128'h0);
  endtask

  // out_ready is owned by this process alone; it changes just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    exp_t         e;
    bit           stall_prev = 1'b0;
    logic [127:0] held_key;
    logic [3:0]   held_round;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && bus.out_valid) begin
          check("stall_key",   bus.out_key,            held_key);
          check("stall_round", 128'(bus.out_round),    128'(held_round));
        end
        if (bus.out_valid && bus.out_ready) begin
          $display("xfer round=%0d key=%h", bus.out_round, bus.out_key);
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_xfer: got round %0d expected none", bus.out_round);
          end else begin
            e = sb_q.pop_front();
            check("xfer_round", 128'(bus.out_round), 128'(e.round));
            if (e.chk_key) check("xfer_key", bus.out_key, e.key);
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held_key   = bus.out_key;
        held_round = bus.out_round;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.key_in = '0;
`ifdef AES_KEY_EXPAND_INV_EN
    bus.inv    = 1'b0;
`endif
    #1;
    check_zero_outputs("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_zero_outputs("post_reset");

    // Back-to-back handshakes with the FIPS-197 key, plus the T+12 busy timing.
    push_fwd(1'b0);
    pulse_start(fips_keys[0], 1'b0);
    check("t1_busy",  128'(bus.busy),      128'(1'b1));
    check("t1_round", 128'(bus.out_round), 128'(4'd0));
    repeat (10) tick();
    check("t11_round", 128'(bus.out_round), 128'(4'd10));
    check("t11_busy",  128'(bus.busy),      128'(1'b1));
    tick();
    check("t12_busy",  128'(bus.busy),      128'(1'b0));
    wait_done();

    // Random back-pressure.
    rand_ready = 1'b1;
    push_fwd(1'b0);
    pulse_start(fips_keys[0], 1'b0);
    wait_done();
    rand_ready = 1'b0;
    tick();

    // A start while busy must be ignored.
    push_fwd(1'b0);
    pulse_start(fips_keys[0], 1'b0);
    wait_round(4'd4);
    bus.key_in = 128'h0;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    check("ignored_start_round", 128'(bus.out_round), 128'(4'd5));
    wait_done();

    // Reset mid-expansion, then a fresh all-zero key.
    push_fwd(1'b0);
    pulse_start(fips_keys[0], 1'b0);
    wait_round(4'd6);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check_zero_outputs("mid_reset");
    tick();
    check_zero_outputs("mid_reset_hold");
    rst = 1'b0;
    tick();
    check_zero_outputs("after_reset");
    push_fwd(1'b1);
    pulse_start(128'h0, 1'b0);
    check("restart_round", 128'(bus.out_round), 128'(4'd0));
    wait_done();

`ifdef AES_KEY_EXPAND_INV_EN
    for (int i = 10; i >= 0; i--) begin
      exp_t e;
      e.round   = 4'(i);
      e.key     = fips_keys[i];
      e.chk_key = 1'b1;
      sb_q.push_back(e);
    end
    pulse_start(fips_keys[10], 1'b1);
    check("inv_first_round", 128'(bus.out_round), 128'(4'd10));
    wait_done();
    bus.inv = 1'b0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
